// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the serial adder datapath: the operand loader
// (piso_operand_tx), its shift lanes and the result SIPO.
//
// Contents:
//   tx_state_t : loader frame state, IDLE (no frame) or SHIFT (frame active)
//   SA_WIDTH   : system default operand width for the loader and result SIPO
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tx_state_t;

    localparam int SA_WIDTH = 4;

endpackage : serial_adder_pkg

// File: rtl/piso_lane.sv
// ---------------------------------------------------------------------------
// piso_lane
//
// One WIDTH-bit parallel-load, shift-right register with hold. The serial
// output is always bit 0, so the operand leaves LSB first. Zeros are shifted
// in at the top.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset, clears the register
//   load     in   capture par_in (highest priority)
//   clear    in   zero the register (end of frame with no new load)
//   shift_en in   shift right by one with zero fill
//   par_in   in   WIDTH-bit parallel operand
//   ser      out  current serial bit (register bit 0)
//
// When load, clear and shift_en are all low the register holds. This is how
// a stalled stream keeps its current bit stable.
// ---------------------------------------------------------------------------
module piso_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser
);

    logic [WIDTH-1:0] sr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= par_in;
        end else if (clear) begin
            sr_reg <= '0;
        end else if (shift_en) begin
            sr_reg <= {1'b0, sr_reg[WIDTH-1:1]};
        end
    end

    assign ser = sr_reg[0];

endmodule : piso_lane

// File: rtl/piso_operand_tx.sv
// ---------------------------------------------------------------------------
// piso_operand_tx
//
// Two-lane parallel-in/serial-out operand loader for the serial adder. It
// accepts an (A, B) operand pair through a valid/ready handshake and streams
// both operands LSB first, one bit per lane on every cycle where shift=1.
// The frame strobes let the adder clear its carry on bit 0.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset; any partial frame is lost
//   shift      in   stream enable, shared with the result SIPO (low = stall)
//   load_valid in   a_par/b_par carry an operand pair
//   load_ready out  a pair can be accepted at the next edge
//   a_par      in   operand A, WIDTH bits
//   b_par      in   operand B, WIDTH bits
//   a_ser      out  current A bit
//   b_ser      out  current B bit
//   bit_valid  out  a_ser/b_ser are consumed at this edge
//   first_bit  out  current bit is bit 0 of the frame (carry clear)
//   last_bit   out  current bit is bit WIDTH-1 of the frame
//   busy       out  a frame is in progress
//
// A pair offered while the last bit is being consumed loads on that same
// edge, so consecutive frames run back to back with no idle cycle. Because of
// this, load_ready depends combinationally on shift.
// ---------------------------------------------------------------------------
module piso_operand_tx
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] a_par,
    input  logic [WIDTH-1:0] b_par,
    output logic             a_ser,
    output logic             b_ser,
    output logic             bit_valid,
    output logic             first_bit,
    output logic             last_bit,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam int LANES = 2;

    tx_state_t     state_reg;
    logic [CW-1:0] cnt_reg;

    logic accept;
    logic advance;
    logic finish;

    logic [LANES-1:0][WIDTH-1:0] lane_par;
    logic [LANES-1:0]            lane_ser;

    // Frame strobes and handshake
    assign busy       = (state_reg == SHIFT);
    assign bit_valid  = busy & shift;
    assign first_bit  = busy & (cnt_reg == '0);
    assign last_bit   = busy & (cnt_reg == LAST_CNT);
    assign load_ready = !busy | (last_bit & shift);

    assign accept  = load_valid & load_ready;
    // An accept takes priority over the end-of-frame clear, and the load
    // overrides the shift inside each lane.
    assign advance = bit_valid & !last_bit;
    assign finish  = bit_valid & last_bit & !accept;

    // Operand lanes: index 0 carries A, index 1 carries B
    assign lane_par[0] = a_par;
    assign lane_par[1] = b_par;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            piso_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clk      (clk),
                .reset    (reset),
                .load     (accept),
                .clear    (finish),
                .shift_en (advance),
                .par_in   (lane_par[gi]),
                .ser      (lane_ser[gi])
            );
        end
    endgenerate

    assign a_ser = lane_ser[0];
    assign b_ser = lane_ser[1];

    // Frame FSM and bit counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (accept) begin
            state_reg <= SHIFT;
            cnt_reg   <= '0;
        end else if (bit_valid) begin
            if (last_bit) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

endmodule : piso_operand_tx

// File: tb/tb_piso_operand_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_operand_tx
//
// Directed bench for piso_operand_tx at WIDTH=4. It includes a small
// behavioural serial adder and result SIPO that are fed from the loader
// outputs. This checks that the carry is cleared on first_bit.
// ---------------------------------------------------------------------------
module tb_piso_operand_tx;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         shift;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] a_par;
    logic [W-1:0] b_par;
    logic         a_ser;
    logic         b_ser;
    logic         bit_valid;
    logic         first_bit;
    logic         last_bit;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    piso_operand_tx #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .shift      (shift),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .a_par      (a_par),
        .b_par      (b_par),
        .a_ser      (a_ser),
        .b_ser      (b_ser),
        .bit_valid  (bit_valid),
        .first_bit  (first_bit),
        .last_bit   (last_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Serial adder + result SIPO fed from the loader outputs
    logic         carry_q = 1'b0;
    logic [W-1:0] sipo_q  = '0;
    logic         cin_w;
    assign cin_w = first_bit ? 1'b0 : carry_q;

    always @(posedge clk) begin
        if (bit_valid) begin
            carry_q <= (a_ser & b_ser) | (a_ser & cin_w) | (b_ser & cin_w);
            sipo_q  <= {a_ser ^ b_ser ^ cin_w, sipo_q[W-1:1]};
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Checks one presented bit of an active, enabled frame
    task automatic bit_chk(input string tag, input logic ea, input logic eb,
                           input logic ef, input logic el);
        chk({tag, "_a"},     {31'd0, a_ser},     {31'd0, ea});
        chk({tag, "_b"},     {31'd0, b_ser},     {31'd0, eb});
        chk({tag, "_first"}, {31'd0, first_bit}, {31'd0, ef});
        chk({tag, "_last"},  {31'd0, last_bit},  {31'd0, el});
        chk({tag, "_valid"}, {31'd0, bit_valid}, 32'd1);
        $display("bit %s a=%0b b=%0b first=%0b last=%0b", tag, a_ser, b_ser, first_bit, last_bit);
    endtask

    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [7:0]   exp_a;
    logic [7:0]   exp_b;

    initial begin
        reset      = 1'b1;
        shift      = 1'b0;
        load_valid = 1'b0;
        a_par      = '0;
        b_par      = '0;

        // Reset state
        #2;
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd1);
        chk("rst_a",     {31'd0, a_ser},      32'd0);
        chk("rst_b",     {31'd0, b_ser},      32'd0);
        chk("rst_valid", {31'd0, bit_valid},  32'd0);
        chk("rst_first", {31'd0, first_bit},  32'd0);
        chk("rst_last",  {31'd0, last_bit},   32'd0);
        $display("reset state checked");
        cyc();
        cyc();
        reset = 1'b0;

        // Basic frame: A=1011, B=0110
        va = 4'b1011;
        vb = 4'b0110;
        a_par = va;
        b_par = vb;
        load_valid = 1'b1;
        shift = 1'b1;
        #1;
        chk("basic_ready_idle", {31'd0, load_ready}, 32'd1);
        cyc();
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            #1;
            bit_chk($sformatf("basic%0d", k), va[k], vb[k], k == 0, k == W - 1);
            chk($sformatf("basic%0d_ready", k), {31'd0, load_ready}, {31'd0, (k == W - 1)});
            cyc();
        end
        chk("basic_busy_after", {31'd0, busy},      32'd0);
        chk("basic_valid_after", {31'd0, bit_valid}, 32'd0);

        // Stall for two cycles after bit 1 is presented
        a_par = va;
        b_par = vb;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        #1;
        bit_chk("stall0", 1'b1, 1'b0, 1'b1, 1'b0);
        cyc();
        shift = 1'b0;
        for (int s = 0; s < 2; s++) begin
            #1;
            chk($sformatf("stall_hold%0d_a", s),     {31'd0, a_ser},      32'd1);
            chk($sformatf("stall_hold%0d_b", s),     {31'd0, b_ser},      32'd1);
            chk($sformatf("stall_hold%0d_valid", s), {31'd0, bit_valid},  32'd0);
            chk($sformatf("stall_hold%0d_ready", s), {31'd0, load_ready}, 32'd0);
            chk($sformatf("stall_hold%0d_busy", s),  {31'd0, busy},       32'd1);
            $display("stall cycle %0d a=%0b b=%0b valid=%0b", s, a_ser, b_ser, bit_valid);
            cyc();
        end
        shift = 1'b1;
        for (int k = 1; k < W; k++) begin
            #1;
            bit_chk($sformatf("stall%0d", k), va[k], vb[k], 1'b0, k == W - 1);
            cyc();
        end
        chk("stall_busy_after", {31'd0, busy}, 32'd0);

        // Back-to-back frames: F/0 then 5/A, no bubble
        exp_a = 8'b0101_1111;
        exp_b = 8'b1010_0000;
        a_par = 4'hF;
        b_par = 4'h0;
        load_valid = 1'b1;
        cyc();
        a_par = 4'h5;
        b_par = 4'hA;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) load_valid = 1'b0;
            #1;
            bit_chk($sformatf("b2b%0d", i), exp_a[i], exp_b[i], (i == 0) || (i == 4), (i == 3) || (i == 7));
            cyc();
        end
        chk("b2b_busy_after", {31'd0, busy}, 32'd0);

        // Ignored offer during bit 2
        va = 4'b1100;
        vb = 4'b0011;
        a_par = va;
        b_par = vb;
        load_valid = 1'b1;
        cyc();
        for (int k = 0; k < W; k++) begin
            if (k == 2) begin
                load_valid = 1'b1;
                a_par = 4'h3;
                b_par = 4'h3;
            end else begin
                load_valid = 1'b0;
            end
            #1;
            bit_chk($sformatf("ign%0d", k), va[k], vb[k], k == 0, k == W - 1);
            chk($sformatf("ign%0d_ready", k), {31'd0, load_ready}, {31'd0, (k == W - 1)});
            cyc();
        end
        load_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("ign_idle%0d", i), {31'd0, busy}, 32'd0);
            cyc();
        end

        // Asynchronous reset mid-frame after 2 bits
        a_par = 4'b1001;
        b_par = 4'b0111;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        #1;
        bit_chk("rmid0", 1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        #1;
        bit_chk("rmid1", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_busy",  {31'd0, busy},       32'd0);
        chk("rmid_ready", {31'd0, load_ready}, 32'd1);
        chk("rmid_a",     {31'd0, a_ser},      32'd0);
        chk("rmid_b",     {31'd0, b_ser},      32'd0);
        chk("rmid_valid", {31'd0, bit_valid},  32'd0);
        chk("rmid_first", {31'd0, first_bit},  32'd0);
        chk("rmid_last",  {31'd0, last_bit},   32'd0);
        $display("mid-frame reset checked");
        #2;
        reset = 1'b0;
        va = 4'b0110;
        vb = 4'b1111;
        a_par = va;
        b_par = vb;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) begin
            #1;
            bit_chk($sformatf("rnew%0d", k), va[k], vb[k], k == 0, k == W - 1);
            cyc();
        end
        chk("rnew_busy_after", {31'd0, busy}, 32'd0);

        // Adder loopback: 7 + 9 = 0x10, then 2 + 3 = 5 with carry cleared
        a_par = 4'h7;
        b_par = 4'h9;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) cyc();
        chk("loop1_sum",   {28'd0, sipo_q},  32'h0);
        chk("loop1_carry", {31'd0, carry_q}, 32'd1);
        $display("loopback 7+9 sum=%0h carry=%0b", sipo_q, carry_q);
        a_par = 4'h2;
        b_par = 4'h3;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
        for (int k = 0; k < W; k++) cyc();
        chk("loop2_sum",   {28'd0, sipo_q},  32'h5);
        chk("loop2_carry", {31'd0, carry_q}, 32'd0);
        $display("loopback 2+3 sum=%0h carry=%0b", sipo_q, carry_q);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_piso_operand_tx

// File: doc/piso_operand_tx.md
# piso_operand_tx

Two-lane parallel-in/serial-out loader that feeds the serial adder. It accepts a pair of WIDTH-bit operands through a valid/ready handshake and streams them LSB-first, one bit per lane per enabled cycle. It drives frame strobes so the adder can clear its carry on the first bit. It is the transmit-side counterpart of the result SIPO and shares the same `shift` enable, so both ends advance on identical clock edges.

## Interface
Parameters:
- `WIDTH`, default 4: operand width in bits. Legal range ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `shift`, input, 1: stream enable shared with the result SIPO; a low level stalls the stream.
- `load_valid`, input, 1: operand pair on `a_par`/`b_par` is offered.
- `load_ready`, output, 1: loader can accept a pair this cycle.
- `a_par`, input, WIDTH: operand A.
- `b_par`, input, WIDTH: operand B.
- `a_ser`, output, 1: current A bit, which is bit 0 of the A shift register.
- `b_ser`, output, 1: current B bit, which is bit 0 of the B shift register.
- `bit_valid`, output, 1: `a_ser`/`b_ser` are consumed at this edge.
- `first_bit`, output, 1: current bit is bit 0 of the frame (carry-clear).
- `last_bit`, output, 1: current bit is bit WIDTH-1 of the frame.
- `busy`, output, 1: frame in progress.

## Operation
States:
- IDLE: no frame is active.
- SHIFT: a frame is active.

Internal registers:
- `a_sr`, `b_sr`: WIDTH bits each.
- `cnt`: width $clog2(WIDTH).

Combinational outputs:
- `busy` = (state == SHIFT).
- `bit_valid` = busy & shift.
- `first_bit` = busy & (cnt == 0).
- `last_bit` = busy & (cnt == WIDTH-1).
- `load_ready` = !busy | (last_bit & shift).

Transitions:
- Accept occurs when load_valid & load_ready at the edge. On accept: a_sr ← a_par, b_sr ← b_par, cnt ← 0, state ← SHIFT.
- In SHIFT with shift=1 and not last: a_sr, b_sr shift right by 1 with 0 fill, cnt ← cnt+1.
- In SHIFT with shift=1 and last, no accept: state ← IDLE, cnt ← 0, shift registers cleared to 0.
- Last bit with a simultaneous accept: the back-to-back frame loads. State stays SHIFT, cnt ← 0, no idle bubble.
- In SHIFT with shift=0: all registers hold. `a_ser`/`b_ser`/strobes stay stable, `bit_valid` is low, and `load_ready` is low.
- In IDLE with shift=0, accept is still allowed; the frame then waits for shift=1.
- `load_valid` while not ready is ignored. The offerer must hold the data; no latching occurs.

Other rules:
- Operands are unsigned bit vectors; no arithmetic is performed here.
- Reset (any time, including mid-frame): state IDLE, a_sr = b_sr = 0, cnt = 0. The partial frame is discarded.
- Output values while reset is asserted: a_ser = b_ser = 0, bit_valid = first_bit = last_bit = busy = 0, load_ready = 1.

## Timing
- Latency from accept edge to first bit presented: 1 cycle. `a_ser` = a_par[0] in the cycle after accept.
- Frame length is exactly WIDTH cycles with bit_valid=1. Stall cycles add to the wall time without adding bits.
- Bit k of each operand is presented in the frame cycle where cnt = k.
- Maximum throughput: one pair per WIDTH cycles, continuous when load_valid is held and shift=1.
- `load_ready` depends combinationally on `shift`. `load_valid` must not depend combinationally on `load_ready`.

## Structure
- Shared package `serial_adder_pkg`:
  - state typedef `tx_state_t` {IDLE, SHIFT};
  - constant `SA_WIDTH` = 4, used as the system default for this block and the result SIPO.
- Sub-module `piso_lane`: a single WIDTH-bit load/shift-right register with hold. It is instantiated twice, once for A and once for B.
- Counter, FSM and handshake stay in the top module.

## Test plan
- Reset check, WIDTH=4: assert reset mid-frame after 2 bits → all outputs zero, load_ready=1 immediately (asynchronous), next accept starts a clean frame with first_bit=1.
- Basic frame: load A=4'b1011, B=4'b0110 with shift=1 → a_ser 1,1,0,1 and b_ser 0,1,1,0 on 4 consecutive bit_valid cycles; first_bit on cycle 1 only, last_bit on cycle 4 only, busy low afterwards.
- Stall: same frame with shift=0 for 2 cycles after bit 1 → outputs hold a_ser=1/b_ser=1 with bit_valid=0, load_ready=0; the stream resumes with bits 2–3 unchanged.
- Back-to-back: load_valid held with A=4'hF,B=4'h0 then A=4'h5,B=4'hA → 8 contiguous bit_valid cycles with no bubble; a_ser 1,1,1,1,1,0,1,0; first_bit on cycles 1 and 5.
- Ignored offer: pulse load_valid with A=4'h3 during bit 2 of a frame → no disturbance to the current frame, and no second frame is started.
- Adder loopback: drive the serial adder and result SIPO from this block with A=4'h7, B=4'h9 → SIPO result 4'h0 with carry-out 1. Then A=4'h2, B=4'h3 → result 4'h5, confirming the first_bit carry clear.
